memory_arbiter: RTL and testbench

Two-port arbiter that shares the single memory_unit between the CPU core (port 0) and a second requester (port 1), such as the program loader or debug port. It runs a 3-state sequencer that registers one access at a time onto the memory side and returns read data and a one-cycle acknowledge to the winning port. Ties are broken round-robin by default.

---
 rtl/memory_arbiter.sv | 161 ++++++++++++++++
 tb/tb_memory_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Two-port arbiter sharing one memory_unit between the CPU (port 0) and a second requester (port 1).
// Define MEMORY_ARBITER_FIXED_PRIORITY_EN for fixed port-0 priority; default build is round-robin.
module memory_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [1:0]            mem_rw_flag,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  grant_id
);

    localparam logic [1:0] MEMORY_STAY  = 2'd0;
    localparam logic [1:0] MEMORY_READ  = 2'd1;
    localparam logic [1:0] MEMORY_WRITE = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_COMPLETE} state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  grant_id_q, grant_id_d;
    logic                  busy_q, busy_d;
    logic                  we_q, we_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]            mem_rw_flag_q, mem_rw_flag_d;

    // A port whose ack is showing this cycle sits out one evaluation, giving the other port a window.
    logic elig0, elig1, pick;
    assign elig0 = req0 & ~ack0_q;
    assign elig1 = req1 & ~ack1_q;

    always_comb begin
        pick = 1'b0;
        if (elig0 && elig1) begin
`ifdef MEMORY_ARBITER_FIXED_PRIORITY_EN
            pick = 1'b0;
`else
            pick = ~last_grant_q;
`endif
        end else begin
            pick = elig1;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_id_d    = grant_id_q;
        busy_d        = busy_q;
        we_d          = we_q;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        mem_rw_flag_d = MEMORY_STAY;

        case (state_q)
            S_IDLE: begin
                busy_d = elig0 | elig1;
                if (elig0 || elig1) begin
                    state_d       = S_ACCESS;
                    grant_id_d    = pick;
                    last_grant_d  = pick;
                    we_d          = pick ? we1 : we0;
                    mem_address_d = pick ? addr1 : addr0;
                    if (pick ? we1 : we0) begin
                        mem_wdata_d   = pick ? wdata1 : wdata0;
                        mem_rw_flag_d = MEMORY_WRITE;
                    end else begin
                        mem_wdata_d   = '0;
                        mem_rw_flag_d = MEMORY_READ;
                    end
                end
            end
            S_ACCESS: begin
                state_d = S_COMPLETE;
                busy_d  = 1'b1;
            end
            S_COMPLETE: begin
                // busy stays up through the ack cycle so it covers the whole transaction.
                state_d = S_IDLE;
                busy_d  = 1'b1;
                if (grant_id_q) begin
                    ack1_d = 1'b1;
                    if (!we_q) rdata1_d = mem_rdata;
                end else begin
                    ack0_d = 1'b1;
                    if (!we_q) rdata0_d = mem_rdata;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            last_grant_q  <= 1'b1;
            grant_id_q    <= 1'b0;
            busy_q        <= 1'b0;
            we_q          <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_rw_flag_q <= MEMORY_STAY;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_id_q    <= grant_id_d;
            busy_q        <= busy_d;
            we_q          <= we_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_rw_flag_q <= mem_rw_flag_d;
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_rw_flag = mem_rw_flag_q;
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a small synchronous memory model.
module tb_memory_arbiter;

    localparam logic [1:0] STAY  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       ack0, ack1, busy, grant_id;
    logic [7:0] rdata0, rdata1, mem_address, mem_wdata;
    logic [7:0] mem_rdata;
    logic [1:0] mem_rw_flag;
    logic [7:0] mem [256];

    int tests  = 0;
    int failed = 0;

    memory_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_address(mem_address), .mem_rw_flag(mem_rw_flag), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
    );

    always #5 CLOCK = ~CLOCK;

    // Memory model: read data appears the cycle after READ is driven.
    always @(posedge CLOCK) begin
        if (RESET) begin
            mem[5]    <= 8'h3C;
            mem[6]    <= 8'h77;
            mem_rdata <= 8'h00;
        end else if (mem_rw_flag == READ) begin
            mem_rdata <= mem[mem_address];
        end else if (mem_rw_flag == WRITE) begin
            mem[mem_address] <= mem_wdata;
        end
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int acks_seen;
    int order [4];
    int both_high;

    initial begin
        RESET = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        tick(); tick();
        RESET = 1'b0;
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_flag", mem_rw_flag, STAY);
        chk("rst_addr", mem_address, 0);
        chk("rst_rdata0", rdata0, 0);

        // Port 0 read of address 5, with the address changing after grant
        req0 = 1; we0 = 0; addr0 = 8'h05;
        tick();
        chk("r0_flag_n1", mem_rw_flag, READ);
        chk("r0_addr_n1", mem_address, 8'h05);
        chk("r0_busy_n1", busy, 1);
        chk("r0_grant", grant_id, 0);
        addr0 = 8'h06;
        tick();
        chk("r0_flag_n2", mem_rw_flag, STAY);
        chk("r0_addr_held", mem_address, 8'h05);
        chk("r0_busy_n2", busy, 1);
        chk("r0_noack_n2", ack0, 0);
        tick();
        chk("r0_ack_n3", ack0, 1);
        chk("r0_rdata", rdata0, 8'h3C);
        chk("r0_ack1_low", ack1, 0);
        chk("r0_busy_n3", busy, 1);
        req0 = 0;
        tick();
        chk("r0_ack_drop", ack0, 0);
        chk("r0_busy_done", busy, 0);
        chk("r0_rdata_hold", rdata0, 8'h3C);

        // Port 1 write A5 to 0x10, then read it back
        req1 = 1; we1 = 1; addr1 = 8'h10; wdata1 = 8'hA5;
        tick();
        chk("w1_flag", mem_rw_flag, WRITE);
        chk("w1_addr", mem_address, 8'h10);
        chk("w1_wdata", mem_wdata, 8'hA5);
        chk("w1_grant", grant_id, 1);
        tick(); tick();
        chk("w1_ack", ack1, 1);
        chk("w1_rdata_unch", rdata1, 0);
        we1 = 0;
        tick();
        chk("w1_ack_drop", ack1, 0);
        chk("w1_ineligible", mem_rw_flag, STAY);
        chk("w1_rdata_unch2", rdata1, 0);
        tick();
        chk("rb1_flag", mem_rw_flag, READ);
        chk("rb1_addr", mem_address, 8'h10);
        tick(); tick();
        chk("rb1_ack", ack1, 1);
        chk("rb1_rdata", rdata1, 8'hA5);
        req1 = 0;
        tick();

        // Both ports requesting continuously
        req0 = 1; we0 = 0; addr0 = 8'h05;
        req1 = 1; we1 = 0; addr1 = 8'h10;
        acks_seen = 0; both_high = 0;
        for (int c = 0; c < 40 && acks_seen < 4; c++) begin
            tick();
            if (ack0 && ack1) both_high++;
            if (ack0) begin order[acks_seen] = 0; acks_seen++; end
            else if (ack1) begin order[acks_seen] = 1; acks_seen++; end
        end
        req0 = 0; req1 = 0;
        chk("rr_ack_count", acks_seen, 4);
        chk("rr_order0", order[0], 0);
        chk("rr_order1", order[1], 1);
        chk("rr_order2", order[2], 0);
        chk("rr_order3", order[3], 1);
        chk("rr_no_overlap", both_high, 0);
        chk("rr_rdata0", rdata0, 8'h3C);
        chk("rr_rdata1", rdata1, 8'hA5);
        tick(); tick(); tick(); tick();
        chk("rr_idle", busy, 0);

        // Request held for one cycle only
        req0 = 1; we0 = 0; addr0 = 8'h06;
        tick();
        chk("drop_flag", mem_rw_flag, READ);
        req0 = 0;
        tick(); tick();
        chk("drop_ack", ack0, 1);
        chk("drop_rdata", rdata0, 8'h77);
        tick();
        chk("drop_ack_low", ack0, 0);

        // Reset while in ACCESS
        req0 = 1; we0 = 0; addr0 = 8'h05;
        tick();
        chk("rsta_flag", mem_rw_flag, READ);
        req0 = 0;
        RESET = 1;
        tick();
        RESET = 0;
        chk("rsta_busy", busy, 0);
        chk("rsta_flag_stay", mem_rw_flag, STAY);
        chk("rsta_ack0", ack0, 0);
        tick();
        chk("rsta_noack_a", ack0, 0);
        tick();
        chk("rsta_noack_b", ack0, 0);
        chk("rsta_idle_flag", mem_rw_flag, STAY);
        req1 = 1; we1 = 0; addr1 = 8'h10;
        tick();
        chk("post_rst_grant", grant_id, 1);
        chk("post_rst_flag", mem_rw_flag, READ);
        tick(); tick();
        chk("post_rst_ack1", ack1, 1);
        chk("post_rst_rdata1", rdata1, 8'hA5);
        req1 = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
